// File: rtl/gelato_writeback_arbiter.sv
// rtl/gelato_writeback_arbiter.sv - round-robin writeback arbiter with registered output and scoreboard release
//
// Shares the single register-file write port among NUM_UNITS execution units.
// One registered output stage with backpressure; a scoreboard release pulse
// follows every completed register-file write by one cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-unit result handshake (one bit per unit)
//   req_warp/rd/data/mask  per-unit result fields, packed unit 0 in the LSBs
//   wb_valid/ready      register-file write handshake
//   wb_warp/rd/data/mask   register-file write fields
//   sb_release_valid    one-cycle pulse freeing a scoreboard entry
//   sb_release_warp/rd  warp and register of the freed entry

module gelato_writeback_arbiter #(
   parameter  int NUM_UNITS = 4,
   parameter  int WARP_NUM  = 4,
   parameter  int REG_W     = 5,
   parameter  int DATA_W    = 256,
   parameter  int MASK_W    = 8,
   localparam int WW        = $clog2(WARP_NUM),
   localparam int UW        = $clog2(NUM_UNITS)
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic [NUM_UNITS-1:0]        req_valid,
   output logic [NUM_UNITS-1:0]        req_ready,
   input  logic [NUM_UNITS*WW-1:0]     req_warp,
   input  logic [NUM_UNITS*REG_W-1:0]  req_rd,
   input  logic [NUM_UNITS*DATA_W-1:0] req_data,
   input  logic [NUM_UNITS*MASK_W-1:0] req_mask,

   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [WW-1:0]               wb_warp,
   output logic [REG_W-1:0]            wb_rd,
   output logic [DATA_W-1:0]           wb_data,
   output logic [MASK_W-1:0]           wb_mask,

   output logic                        sb_release_valid,
   output logic [WW-1:0]               sb_release_warp,
   output logic [REG_W-1:0]            sb_release_rd
);

   logic [UW-1:0]     last_grant;
   logic [UW-1:0]     grant_idx;
   logic [UW-1:0]     cand;
   logic              any_req;
   logic              load_en;
   logic              grant;
   logic              wb_hs;

   logic [WW-1:0]     sel_warp;
   logic [REG_W-1:0]  sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic [MASK_W-1:0] sel_mask;

   // The output register may refill in the same cycle its entry drains.
   assign load_en = !wb_valid || wb_ready;
   assign wb_hs   = wb_valid && wb_ready;
   assign grant   = load_en && any_req;

   // Round-robin scan starting one past the previous winner, wrapping around.
   always_comb begin
      any_req   = 1'b0;
      grant_idx = last_grant;
      cand      = '0;
      for (int i = 1; i <= NUM_UNITS; i++) begin
         cand = UW'((int'(last_grant) + i) % NUM_UNITS);
         if (!any_req && req_valid[cand]) begin
            any_req   = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Field mux for the winning unit; constant slice indices only.
   always_comb begin
      sel_warp = req_warp[WW-1:0];
      sel_rd   = req_rd[REG_W-1:0];
      sel_data = req_data[DATA_W-1:0];
      sel_mask = req_mask[MASK_W-1:0];
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (grant_idx == UW'(i)) begin
            sel_warp = req_warp[i*WW +: WW];
            sel_rd   = req_rd[i*REG_W +: REG_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
            sel_mask = req_mask[i*MASK_W +: MASK_W];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Output stage. A grant for register 0 consumes the result without a
   // write, so the stage behaves as if no grant had occurred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= UW'(NUM_UNITS - 1);
         wb_valid   <= 1'b0;
         wb_warp    <= '0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_mask    <= '0;
      end else begin
         if (grant) begin
            last_grant <= grant_idx;
         end
         if (grant && (sel_rd != '0)) begin
            wb_valid <= 1'b1;
            wb_warp  <= sel_warp;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
            wb_mask  <= sel_mask;
         end else if (wb_hs) begin
            wb_valid <= 1'b0;
         end
      end
   end

   // Release captures the committed entry before the output stage is
   // overwritten by a same-cycle load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_release_valid <= 1'b0;
         sb_release_warp  <= '0;
         sb_release_rd    <= '0;
      end else begin
         sb_release_valid <= wb_hs;
         if (wb_hs) begin
            sb_release_warp <= wb_warp;
            sb_release_rd   <= wb_rd;
         end
      end
   end

endmodule

// File: tb/tb_gelato_writeback_arbiter.sv
// tb/tb_gelato_writeback_arbiter.sv - directed table-driven bench for gelato_writeback_arbiter

module tb_gelato_writeback_arbiter;

   localparam int NU = 4;
   localparam int WW = 2;
   localparam int RW = 5;
   localparam int DW = 256;
   localparam int MW = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NU-1:0]    req_valid;
   logic [NU-1:0]    req_ready;
   logic [NU*WW-1:0] req_warp;
   logic [NU*RW-1:0] req_rd;
   logic [NU*DW-1:0] req_data;
   logic [NU*MW-1:0] req_mask;
   logic             wb_valid;
   logic             wb_ready;
   logic [WW-1:0]    wb_warp;
   logic [RW-1:0]    wb_rd;
   logic [DW-1:0]    wb_data;
   logic [MW-1:0]    wb_mask;
   logic             sb_release_valid;
   logic [WW-1:0]    sb_release_warp;
   logic [RW-1:0]    sb_release_rd;

   int checks = 0;
   int errors = 0;

   gelato_writeback_arbiter #(
      .NUM_UNITS(NU), .WARP_NUM(4), .REG_W(RW), .DATA_W(DW), .MASK_W(MW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
      .req_rd(req_rd), .req_data(req_data), .req_mask(req_mask),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_mask(wb_mask),
      .sb_release_valid(sb_release_valid), .sb_release_warp(sb_release_warp),
      .sb_release_rd(sb_release_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [7:0]  w;
      logic [19:0] r;
      logic        rdy;
      logic [3:0]  e_ready;
      logic        e_wbv;
      int          e_unit;
      logic [1:0]  e_warp;
      logic [4:0]  e_rd;
      logic        e_relv;
      logic [1:0]  e_rwarp;
      logic [4:0]  e_rrd;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] mk_data(int u, logic [1:0] w, logic [4:0] r);
      return {8{8'hA5, 8'(u), 6'b0, w, 3'b0, r}};
   endfunction

   function automatic logic [MW-1:0] mk_mask(int u);
      case (u)
         0:       return 8'h81;
         1:       return 8'h3C;
         2:       return 8'hFF;
         default: return 8'h0F;
      endcase
   endfunction

   function automatic void add(int v, logic [7:0] w, logic [19:0] r, int rdy,
                               int er, int ewv, int eu, int ew, int erd,
                               int erv, int erw, int errd);
      vec_t t;
      t.v = 4'(v); t.w = w; t.r = r; t.rdy = 1'(rdy);
      t.e_ready = 4'(er); t.e_wbv = 1'(ewv); t.e_unit = eu;
      t.e_warp = 2'(ew); t.e_rd = 5'(erd);
      t.e_relv = 1'(erv); t.e_rwarp = 2'(erw); t.e_rrd = 5'(errd);
      vecs.push_back(t);
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [3:0] v, logic [7:0] w, logic [19:0] r, logic rdy);
      req_valid = v;
      req_warp  = w;
      req_rd    = r;
      wb_ready  = rdy;
      for (int i = 0; i < NU; i++) begin
         req_data[i*DW +: DW] = mk_data(i, w[i*WW +: WW], r[i*RW +: RW]);
         req_mask[i*MW +: MW] = mk_mask(i);
      end
   endtask

   task automatic chk_wb(string tag, int u, logic [1:0] w, logic [4:0] r);
      chk({tag, " wb_warp"}, DW'(wb_warp), DW'(w));
      chk({tag, " wb_rd"},   DW'(wb_rd),   DW'(r));
      chk({tag, " wb_data"}, wb_data,      mk_data(u, w, r));
      chk({tag, " wb_mask"}, DW'(wb_mask), DW'(mk_mask(u)));
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, " wb_valid"},  DW'(wb_valid),         '0);
      chk({tag, " wb_warp"},   DW'(wb_warp),          '0);
      chk({tag, " wb_rd"},     DW'(wb_rd),            '0);
      chk({tag, " wb_data"},   wb_data,               '0);
      chk({tag, " wb_mask"},   DW'(wb_mask),          '0);
      chk({tag, " rel_valid"}, DW'(sb_release_valid), '0);
      chk({tag, " rel_warp"},  DW'(sb_release_warp),  '0);
      chk({tag, " rel_rd"},    DW'(sb_release_rd),    '0);
   endtask

   localparam logic [7:0]  WA  = {2'd0, 2'd1, 2'd0, 2'd0};
   localparam logic [19:0] RA  = {5'd0, 5'd7, 5'd0, 5'd0};
   localparam logic [7:0]  WD  = {2'd2, 6'd0};
   localparam logic [19:0] RD0 = 20'd0;
   localparam logic [7:0]  WB  = {2'd3, 2'd2, 2'd1, 2'd0};
   localparam logic [19:0] RB  = {5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [7:0]  WC  = {4'd0, 2'd2, 2'd1};
   localparam logic [19:0] RC  = {10'd0, 5'd6, 5'd5};
   localparam logic [7:0]  WE1 = 8'd0;
   localparam logic [19:0] RE1 = {15'd0, 5'd4};
   localparam logic [7:0]  WE2 = {4'd0, 2'd2, 2'd0};
   localparam logic [19:0] RE2 = {10'd0, 5'd9, 5'd0};

   initial begin
      // v, warp, rd, wb_ready | req_ready, wb_valid, unit, warp, rd, rel_valid, rel_warp, rel_rd
      // single request from unit 2
      add(4'b0100, WA, RA, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
      add(4'b0000, WA, RA, 1, 4'b0000, 1, 2, 1, 7, 0, 0, 0);
      add(4'b0000, WA, RA, 1, 4'b0000, 0, 0, 0, 0, 1, 1, 7);
      // rd 0 from unit 3 while idle: consumed, nothing written or released
      add(4'b1000, WD, RD0, 1, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
      add(4'b0000, WD, RD0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
      // all four units streaming
      add(4'b1111, WB, RB, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
      add(4'b1111, WB, RB, 1, 4'b0010, 1, 0, 0, 1, 0, 0, 0);
      add(4'b1111, WB, RB, 1, 4'b0100, 1, 1, 1, 2, 1, 0, 1);
      add(4'b1111, WB, RB, 1, 4'b1000, 1, 2, 2, 3, 1, 1, 2);
      add(4'b1111, WB, RB, 1, 4'b0001, 1, 3, 3, 4, 1, 2, 3);
      add(4'b0000, WB, RB, 1, 4'b0000, 1, 0, 0, 1, 1, 3, 4);
      add(4'b0000, WB, RB, 1, 4'b0000, 0, 0, 0, 0, 1, 0, 1);
      add(4'b0000, WB, RB, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
      // rd 0 from unit 3 again to re-aim priority at unit 0
      add(4'b1000, WD, RD0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
      // backpressure with units 0 and 1 requesting
      add(4'b0011, WC, RC, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         add(4'b0011, WC, RC, 0, 4'b0000, 1, 0, 1, 5, 0, 0, 0);
      add(4'b0011, WC, RC, 1, 4'b0010, 1, 0, 1, 5, 0, 0, 0);
      add(4'b0001, WC, RC, 1, 4'b0001, 1, 1, 2, 6, 1, 1, 5);
      add(4'b0000, WC, RC, 1, 4'b0000, 1, 0, 1, 5, 1, 2, 6);
      add(4'b0000, WC, RC, 1, 4'b0000, 0, 0, 0, 0, 1, 1, 5);
      // drain and load in the same cycle
      add(4'b0001, WE1, RE1, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
      add(4'b0010, WE2, RE2, 0, 4'b0000, 1, 0, 0, 4, 0, 0, 0);
      add(4'b0010, WE2, RE2, 1, 4'b0010, 1, 0, 0, 4, 0, 0, 0);
      add(4'b0000, WE2, RE2, 0, 4'b0000, 1, 1, 2, 9, 1, 0, 4);
      add(4'b0000, WE2, RE2, 0, 4'b0000, 1, 1, 2, 9, 0, 0, 0);
      // rd 0 grant while the entry drains: wb_valid falls
      add(4'b1000, WD, RD0, 1, 4'b1000, 1, 1, 2, 9, 0, 0, 0);
      add(4'b0000, WD, RD0, 1, 4'b0000, 0, 0, 0, 0, 1, 2, 9);

      rst_n = 1'b0;
      drive(4'b0000, 8'd0, 20'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset req_ready", DW'(req_ready), '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k].v, vecs[k].w, vecs[k].r, vecs[k].rdy);
         #1;
         chk($sformatf("v%0d req_ready", k), DW'(req_ready), DW'(vecs[k].e_ready));
         chk($sformatf("v%0d wb_valid", k), DW'(wb_valid), DW'(vecs[k].e_wbv));
         if (vecs[k].e_wbv)
            chk_wb($sformatf("v%0d", k), vecs[k].e_unit, vecs[k].e_warp, vecs[k].e_rd);
         chk($sformatf("v%0d rel_valid", k), DW'(sb_release_valid), DW'(vecs[k].e_relv));
         if (vecs[k].e_relv) begin
            chk($sformatf("v%0d rel_warp", k), DW'(sb_release_warp), DW'(vecs[k].e_rwarp));
            chk($sformatf("v%0d rel_rd", k), DW'(sb_release_rd), DW'(vecs[k].e_rrd));
         end
      end

      // reset while an entry is pending: it is discarded, priority restarts at unit 0
      @(negedge clk);
      drive(4'b0010, {4'd0, 2'd3, 2'd0}, {10'd0, 5'd11, 5'd0}, 1'b0);
      #1;
      chk("mid req_ready", DW'(req_ready), DW'(4'b0010));
      @(negedge clk);
      drive(4'b0000, 8'd0, 20'd0, 1'b0);
      #1;
      chk("mid wb_valid", DW'(wb_valid), DW'(1'b1));
      chk_wb("mid", 1, 2'd3, 5'd11);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1111, WB, RB, 1'b1);
      #1;
      chk("post reset req_ready", DW'(req_ready), DW'(4'b0001));
      @(negedge clk);
      drive(4'b0000, WB, RB, 1'b1);
      #1;
      chk("post reset wb_valid", DW'(wb_valid), DW'(1'b1));
      chk_wb("post reset", 0, 2'd0, 5'd1);
      chk("post reset rel_valid", DW'(sb_release_valid), '0);
      @(negedge clk);
      #1;
      chk("post reset release", DW'(sb_release_valid), DW'(1'b1));
      chk("post reset rel_rd", DW'(sb_release_rd), DW'(5'd1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gelato_writeback_arbiter.md
# gelato_writeback_arbiter

Round-robin arbiter that shares the single register-file write port among the execution units and frees scoreboard entries after each write commits. Sits between the execution units and the register file/scoreboard. It closes the loop with the warp scheduler, which stalls a warp while its destination register is pending in the scoreboard. It has one registered output stage with backpressure. Scoreboard release is issued only after the register-file write handshake completes.

## Interface
- NUM_UNITS, 4, number of execution-unit requesters (≥2)
- WARP_NUM, 4, number of warps; WW = $clog2(WARP_NUM)
- REG_W, 5, register address width
- DATA_W, 256, writeback data width (all lanes)
- MASK_W, 8, per-lane write mask width
- UW, $clog2(NUM_UNITS), derived unit-index width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_UNITS  unit i has a result
- req_ready  out  NUM_UNITS  unit i result consumed this cycle
- req_warp  in  NUM_UNITS×WW  warp of unit i result
- req_rd  in  NUM_UNITS×REG_W  destination register of unit i
- req_data  in  NUM_UNITS×DATA_W  result data of unit i
- req_mask  in  NUM_UNITS×MASK_W  lane mask of unit i
- wb_valid  out  1  register-file write pending
- wb_ready  in  1  register file accepts write
- wb_warp  out  WW  write warp
- wb_rd  out  REG_W  write register
- wb_data  out  DATA_W  write data
- wb_mask  out  MASK_W  write lane mask
- sb_release_valid  out  1  one-cycle pulse; free scoreboard entry
- sb_release_warp  out  WW  warp of freed entry
- sb_release_rd  out  REG_W  register of freed entry

## Operation
- load_en = !wb_valid || wb_ready. The output register can take a new result in the same cycle the current one drains.
- Arbitration is combinational. Scan units starting at (last_grant+1) mod NUM_UNITS with wrap-around. The first unit with req_valid wins (grant g).
- req_ready[g] = load_en && any req_valid. All other req_ready bits are 0. There is at most one grant per cycle.
- On grant with req_rd[g] != 0:
  - Load wb_warp/rd/data/mask from unit g.
  - Set wb_valid = 1.
- On grant with req_rd[g] == 0:
  - The result is consumed and dropped. There is no register-file write and no release.
  - If the current entry drains in that cycle, wb_valid falls to 0.
- last_grant <= g on every grant, including rd==0 grants.
- If no grant and wb_ready && wb_valid, then wb_valid <= 0.
- Output fields are held stable while wb_valid && !wb_ready.
- Release: on a wb handshake (wb_valid && wb_ready), the next cycle asserts sb_release_valid = 1 for exactly one cycle, with sb_release_warp/rd equal to the committed wb_warp/rd.
- Back-to-back handshakes produce back-to-back release pulses.
- Requesters must hold req_* stable until their req_ready. Unit i deasserting req_valid without ready is a protocol violation; no behaviour is defined.

## Timing
- Reset values:
  - wb_valid 0; wb_warp, wb_rd, wb_data, wb_mask 0.
  - sb_release_valid 0; sb_release_warp, sb_release_rd 0.
  - last_grant = NUM_UNITS-1, so unit 0 has first priority.
- Latency:
  - req handshake to wb_valid: 1 cycle.
  - wb handshake to sb_release_valid: 1 cycle.
  - Minimum req-to-release: 2 cycles.
- Throughput is 1 result/cycle when wb_ready is held high.
- Fairness: a continuously requesting unit is granted within NUM_UNITS grants.
- Reset asserted mid-operation: the pending wb entry is discarded and its release is lost. The scoreboard is reset by the same rst_n.
- Simultaneous grant and drain: the new data loads and the old entry releases next cycle. The release fields must come from the committed entry, not from the newly loaded one.

## Test plan
- Reset, single request: unit 2 sends warp 1, rd 7, data 0xA5…, mask 0xFF with wb_ready = 1.
  - Cycle 1: req_ready[2].
  - Cycle 2: wb_valid with those fields.
  - Cycle 3: sb_release_valid, warp 1, rd 7.
- All 4 units request continuously with wb_ready = 1: grant order is 0,1,2,3,0,1…; one wb per cycle; release pulses on consecutive cycles.
- Backpressure:
  - Hold wb_ready = 0 for 5 cycles with units 0 and 1 requesting.
  - wb_* stay stable; req_ready stays all 0; no sb_release_valid.
  - After wb_ready rises, unit 1 is granted in that same cycle.
- rd==0 request: unit 3 sends rd 0 while idle. req_ready[3] = 1; wb_valid stays 0; no release. The next grant starts at unit 0.
- Drain plus load in the same cycle: wb holds warp 0 rd 4, wb_ready = 1, unit 1 requests warp 2 rd 9.
  - Next cycle: wb shows warp 2 rd 9 and sb_release shows warp 0 rd 4.
- Reset mid-flight with wb_valid = 1: after rst_n rises, all outputs are 0 and the first grant goes to unit 0.
